// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - OP_* : encoding of the op input (MULT, MULTU, DIV, DIVU)
//   - state_e : sequencing states of the top-level FSM
package hilo_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: iterative multiply/divide datapath.
//   clk, rst  : falling-edge clock, synchronous active-high reset
//   start     : latch op/a/b (asserted by the FSM when an operation is accepted)
//   prep      : compute magnitudes and signs, load counter and accumulator
//   calc      : perform one shift-add / shift-subtract step
//   op, a, b  : operation and operands
//   result_hi : HI result (product upper half or remainder), sign-corrected
//   result_lo : LO result (product lower half or quotient), sign-corrected
//   calc_last : this calc step is the final iteration
//   valid     : all iterations completed; results are final
module muldiv_core
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             prep,
  input  logic             calc,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             calc_last,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         op_q,      op_d;
  logic [WIDTH-1:0]   a_q,       a_d;
  logic [WIDTH-1:0]   b_q,       b_d;
  logic [WIDTH-1:0]   mag_a_q,   mag_a_d;
  logic [WIDTH-1:0]   mag_b_q,   mag_b_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic               fin_q,     fin_d;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   quo_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

  // Negating the most negative value yields 2^(WIDTH-1), which is exactly
  // the required unsigned magnitude.
  assign abs_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign abs_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Multiply: acc = {partial product, remaining multiplier bits}. Add the
  // multiplicand when the current multiplier LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}.
  // Shift left one bit, trial-subtract the divisor; bit WIDTH of the
  // difference is the borrow (remainder < divisor -> restore).
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign quo_sh   = {acc_q[WIDTH-2:0], 1'b0};
  assign rem_diff = rem_sh - {1'b0, mag_b_q};
  assign div_step = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], quo_sh}
                                    : {rem_diff[WIDTH-1:0], quo_sh[WIDTH-1:1], 1'b1};

  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    fin_d     = fin_q;
    if (start) begin
      op_d  = op;
      a_d   = a;
      b_d   = b;
      fin_d = 1'b0;
    end
    if (prep) begin
      mag_a_d   = abs_a;
      mag_b_d   = abs_b;
      neg_res_d = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
      neg_rem_d = is_signed && a_q[WIDTH-1];
      cnt_d     = CW'(WIDTH);
      acc_d     = is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
    end
    if (calc) begin
      acc_d = is_div ? div_step : mul_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        fin_d = 1'b1;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      op_q      <= OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      fin_q     <= 1'b0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      fin_q     <= fin_d;
    end
  end

  // Sign correction and divide-by-zero override.
  assign product = neg_res_q ? -acc_q : acc_q;
  assign quo     = acc_q[WIDTH-1:0];
  assign rem     = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    result_hi = product[2*WIDTH-1:WIDTH];
    result_lo = product[WIDTH-1:0];
    if (is_div) begin
      if (b_q == '0) begin
        result_hi = a_q;
        result_lo = '1;
      end else begin
        result_hi = neg_rem_q ? -rem : rem;
        result_lo = neg_res_q ? -quo : quo;
      end
    end
  end

  assign calc_last = (cnt_q == CW'(1));
  assign valid     = fin_q;

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: architectural HI/LO registers with an iterative
// MULT/MULTU/DIV/DIVU engine. All state changes on the falling clock edge.
//   clk, rst           : clock, synchronous active-high reset
//   start, op, a, b    : launch an operation (accepted only when idle)
//   hi_we, lo_we, wdata: MTHI/MTLO writes (dropped while busy)
//   hi_oe, lo_oe       : read gates for hi_rdata / lo_rdata
//   hi_rdata, lo_rdata : gated HI/LO contents (0 when not enabled)
//   busy               : operation in flight
//   done               : one-cycle pulse when results land in HI/LO
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hi_oe,
  input  logic             lo_oe,
  output logic [WIDTH-1:0] hi_rdata,
  output logic [WIDTH-1:0] lo_rdata,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;

  logic             core_start;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic             core_last;
  logic             core_valid;

  // A start outside IDLE is ignored, so operands are only latched here.
  assign core_start = (state_q == ST_IDLE) && start;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .prep      (state_q == ST_PREP),
    .calc      (state_q == ST_CALC),
    .op        (op),
    .a         (a),
    .b         (b),
    .result_hi (core_hi),
    .result_lo (core_lo),
    .calc_last (core_last),
    .valid     (core_valid)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        // Direct writes land even when start is accepted in the same cycle;
        // FIX overwrites both registers later.
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d = ST_PREP;
          busy_d  = 1'b1;
        end
      end
      ST_PREP: state_d = ST_CALC;
      ST_CALC: begin
        if (core_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (core_valid) begin
          hi_d   = core_hi;
          lo_d   = core_lo;
          done_d = 1'b1;
        end
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_rdata = hi_oe ? hi_q : '0;
  assign lo_rdata = lo_oe ? lo_q : '0;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised HI/LO register pair with an integrated iterative multiply/divide engine for the multi-cycle MIPS datapath. It holds the architectural HI and LO registers and serves MTHI/MTLO writes and gated MFHI/MFLO reads. It also executes MULT, MULTU, DIV and DIVU over multiple cycles, with a busy/done handshake toward the control unit. It replaces the single-register HI storage element and adds the arithmetic sequencing that storage element lacked.

## Interface
Parameters:
- WIDTH, 32, data width of operands, HI and LO.

Ports:
- clk  in  1  clock; all state updates on the falling edge of clk.
- rst  in  1  synchronous active-high reset, sampled on the same falling edge.
- start  in  1  launch the operation selected by op; sampled only in IDLE.
- op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend), captured at start.
- b  in  WIDTH  rt operand (multiplier / divisor), captured at start.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  data for MTHI/MTLO.
- hi_oe  in  1  HI read enable.
- lo_oe  in  1  LO read enable.
- hi_rdata  out  WIDTH  HI when hi_oe, else 0; combinational.
- lo_rdata  out  WIDTH  LO when lo_oe, else 0; combinational.
- busy  out  1  high while an operation is in flight.
- done  out  1  single-cycle pulse when results are written to HI/LO.

## Operation
- FSM states: IDLE, PREP, CALC, FIX.
- IDLE, start=1: latch a, b, op, go to PREP. start=0: stay.
- PREP: compute magnitudes. Signed ops take the absolute value of each operand and record the result sign and remainder sign; unsigned ops pass the operands through. Load the iteration counter with WIDTH. Go to CALC.
- CALC, one bit per cycle:
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, producing a WIDTH-bit quotient and remainder.
  - Decrement the counter; when it reaches 0, go to FIX.
- FIX: apply the sign correction and write the results, pulse done, return to IDLE.
  - Multiply: HI = upper half of the product, LO = lower half. For signed ops, negate the product when the operand signs differ.
  - Divide: LO = quotient, HI = remainder. The quotient takes the sign of a XOR b; the remainder takes the sign of a.
- Arithmetic is unsigned modulo 2^WIDTH on the magnitudes. The absolute value of the most negative number, -2^(WIDTH-1), is representable as an unsigned magnitude.
- Divide by zero, b=0, all ops: LO = all ones, HI = a. Takes the same latency; no exception.
- Signed overflow, -2^(WIDTH-1) / -1: LO = -2^(WIDTH-1), HI = 0.
- Direct writes:
  - In IDLE, hi_we loads HI from wdata and lo_we loads LO from wdata; both may assert in the same cycle.
  - Writes while busy=1 are dropped.
  - start and a write in the same IDLE cycle: the write applies, the operation starts, and FIX later overwrites both HI and LO.
- start while busy is ignored.
- Reads always show the current HI/LO registers. During busy they show the pre-operation values.

## Timing
- Reset values: HI=0, LO=0, busy=0, done=0, state IDLE. Both read outputs are 0 regardless of oe while HI/LO are 0.
- Reset mid-operation: next edge returns to IDLE, clears HI/LO and counter, and emits no done.
- Latency: start sampled at edge N; busy=1 from N through N+WIDTH+1; FIX at edge N+WIDTH+2 writes HI/LO and asserts done for that one cycle; busy=0 in the same cycle. Total is WIDTH+2 cycles, 34 for WIDTH=32.
- A new start is accepted in the cycle after done, since the FSM is back in IDLE.
- MTHI/MTLO: write at edge N is visible on the read outputs after edge N.

## Structure
- Package hilo_pkg: the op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state encoding.
- Sub-module muldiv_core: PREP/CALC/FIX datapath (magnitudes, counter, accumulator/remainder, sign fix) with start/op/a/b in and result_hi/result_lo/valid out.
- hilo_muldiv top: the FSM handshake, HI/LO registers, write arbitration and output gating.

## Test plan
- Reset, then raise hi_oe and lo_oe -> hi_rdata=0, lo_rdata=0, busy=0. Assert rst mid-DIV -> next cycle busy=0, HI=LO=0, no done.
- MTHI 0xDEADBEEF, MTLO 0x12345678; reads with oe=0 -> 0; with oe=1 -> those values. MTHI during busy -> HI unchanged.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> done exactly 34 cycles after start; HI=0xFFFFFFFE, LO=0x00000001. MULT -3 × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100 / 7 -> LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5.
- Back-to-back: second start pulsed while busy is ignored. Start re-issued in the cycle after done -> accepted; second result correct; done pulses once per accepted operation.
